// File: rtl/mini_src_pkg.sv
// Shared Mini SRC definitions: branch sequencer states, ISA opcodes, IR fields
// and the control-step strobe bundle with its per-state decoder.
package mini_src_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T1W  = 4'd3,
        ST_T2   = 4'd4,
        ST_CHK  = 4'd5,
        ST_T3   = 4'd6,
        ST_T4   = 4'd7,
        ST_T5   = 4'd8,
        ST_T6   = 4'd9,
        ST_DONE = 4'd10
    } br_state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_C2_MSB = 20;
    localparam int IR_C2_LSB = 19;

    localparam logic [1:0] C2_BRZR = 2'b00;
    localparam logic [1:0] C2_BRNZ = 2'b01;
    localparam logic [1:0] C2_BRPL = 2'b10;
    localparam logic [1:0] C2_BRMI = 2'b11;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic z_in;
        logic zlow_out;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic gra;
        logic r_out;
        logic con_in;
        logic y_in;
        logic c_out;
        logic add;
    } strobe_t;

    // PC is only rewritten in T6 when the sampled branch flag says so.
    function automatic strobe_t decode_strobes(input br_state_t st, input logic take);
        strobe_t s;
        s = '0;
        case (st)
            ST_T0:  begin s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; s.z_in = 1'b1; end
            ST_T1:  begin s.zlow_out = 1'b1; s.pc_in = 1'b1; s.read = 1'b1; s.mdr_in = 1'b1; end
            ST_T1W: begin s.read = 1'b1; s.mdr_in = 1'b1; end
            ST_T2:  begin s.mdr_out = 1'b1; s.ir_in = 1'b1; end
            ST_T3:  begin s.gra = 1'b1; s.r_out = 1'b1; s.con_in = 1'b1; end
            ST_T4:  begin s.pc_out = 1'b1; s.y_in = 1'b1; end
            ST_T5:  begin s.c_out = 1'b1; s.add = 1'b1; s.z_in = 1'b1; end
            ST_T6:  begin s.zlow_out = 1'b1; s.pc_in = take; end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/branch_seq_stats.sv
// Taken / not-taken branch counters; only built when BRANCH_SEQ_STATS_EN is defined.
`ifdef BRANCH_SEQ_STATS_EN
module branch_seq_stats (
    input  logic        clock,
    input  logic        reset,
    input  logic        t6_i,
    input  logic        take_i,
    output logic [15:0] taken_cnt_o,
    output logic [15:0] nottaken_cnt_o
);

    logic [15:0] taken_q;
    logic [15:0] nottaken_q;

    // T6 lasts exactly one cycle per branch, so counting while in it counts each branch once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            taken_q    <= '0;
            nottaken_q <= '0;
        end else if (t6_i) begin
            if (take_i) taken_q    <= taken_q + 16'd1;
            else        nottaken_q <= nottaken_q + 16'd1;
        end
    end

    assign taken_cnt_o    = taken_q;
    assign nottaken_cnt_o = nottaken_q;

endmodule
`endif

// File: rtl/branch_seq_ctrl.sv
// Fetch (T0-T2) plus branch execute (T3-T6) control-step sequencer for Mini SRC.
// Optional taken/not-taken statistics are enabled by defining BRANCH_SEQ_STATS_EN.
module branch_seq_ctrl
    import mini_src_pkg::*;
#(
    parameter logic [4:0] BR_OPCODE   = OP_BR,
    parameter int         MEM_TIMEOUT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  ir_op,
    input  logic        mem_ready,
    input  logic        branch,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Zlowout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Gra,
    output logic        Rout,
    output logic        CONin,
    output logic        Yin,
    output logic        Cout,
    output logic        ADD,
    output logic        busy,
    output logic        done,
    output logic        not_branch,
    output logic        mem_err
`ifdef BRANCH_SEQ_STATS_EN
    ,
    output logic [15:0] taken_cnt,
    output logic [15:0] nottaken_cnt
`endif
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    br_state_t  state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       take_q, take_d;
    logic       err_q, err_d;
    logic       nb_d;
    strobe_t    strobe_q, strobe_d;
    logic       busy_q, done_q, not_branch_q;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path can infer a latch.
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        take_d     = take_q;
        err_d      = err_q;
        nb_d       = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_T0;
                err_d   = 1'b0;
            end
            ST_T0: state_d = ST_T1;
            ST_T1: begin
                state_d    = ST_T1W;
                wait_cnt_d = '0;
            end
            ST_T1W: begin
                if (mem_ready) begin
                    state_d = ST_T2;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (wait_cnt_q != 8'hFF) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_T2: state_d = ST_CHK;
            ST_CHK: begin
                if (ir_op == BR_OPCODE) begin
                    state_d = ST_T3;
                end else begin
                    nb_d    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_T3: state_d = ST_T4;
            ST_T4: state_d = ST_T5;
            ST_T5: begin
                take_d  = branch;
                state_d = ST_T6;
            end
            ST_T6:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        strobe_d = decode_strobes(state_d, take_d);
    end

    // Outputs are registered from the next state so each one is a clean flop output aligned with state_q.
    // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            take_q       <= 1'b0;
            err_q        <= 1'b0;
            strobe_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            not_branch_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            take_q       <= take_d;
            err_q        <= err_d;
            strobe_q     <= strobe_d;
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_d == ST_DONE);
            not_branch_q <= nb_d;
        end
    end

    assign PCout      = strobe_q.pc_out;
    assign MARin      = strobe_q.mar_in;
    assign IncPC      = strobe_q.inc_pc;
    assign Zin        = strobe_q.z_in;
    assign Zlowout    = strobe_q.zlow_out;
    assign PCin       = strobe_q.pc_in;
    assign Read       = strobe_q.read;
    assign MDRin      = strobe_q.mdr_in;
    assign MDRout     = strobe_q.mdr_out;
    assign IRin       = strobe_q.ir_in;
    assign Gra        = strobe_q.gra;
    assign Rout       = strobe_q.r_out;
    assign CONin      = strobe_q.con_in;
    assign Yin        = strobe_q.y_in;
    assign Cout       = strobe_q.c_out;
    assign ADD        = strobe_q.add;
    assign busy       = busy_q;
    assign done       = done_q;
    assign not_branch = not_branch_q;
    assign mem_err    = err_q;

`ifdef BRANCH_SEQ_STATS_EN
    branch_seq_stats u_stats (
        .clock          (clock),
        .reset          (reset),
        .t6_i           (state_q == ST_T6),
        .take_i         (take_q),
        .taken_cnt_o    (taken_cnt),
        .nottaken_cnt_o (nottaken_cnt)
    );
`endif

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Directed self-checking bench for branch_seq_ctrl with hand-computed strobe tables.
module tb_branch_seq_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] ir_op;
    logic       mem_ready;
    logic       branch;
    logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin;
    logic MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD;
    logic busy, done, not_branch, mem_err;
`ifdef BRANCH_SEQ_STATS_EN
    logic [15:0] taken_cnt, nottaken_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] strobes;
    logic [15:0] exp_q[$];

    // Bit order: PCout MARin IncPC Zin Zlowout PCin Read MDRin MDRout IRin Gra Rout CONin Yin Cout ADD
    localparam logic [15:0] S_T0   = 16'hF000;
    localparam logic [15:0] S_T1   = 16'h0F00;
    localparam logic [15:0] S_T1W  = 16'h0300;
    localparam logic [15:0] S_T2   = 16'h00C0;
    localparam logic [15:0] S_NONE = 16'h0000;
    localparam logic [15:0] S_T3   = 16'h0038;
    localparam logic [15:0] S_T4   = 16'h8004;
    localparam logic [15:0] S_T5   = 16'h1003;
    localparam logic [15:0] S_T6T  = 16'h0C00;
    localparam logic [15:0] S_T6N  = 16'h0800;

    assign strobes = {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
                      MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD};

    always #5 clock = ~clock;

    branch_seq_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .ir_op      (ir_op),
        .mem_ready  (mem_ready),
        .branch     (branch),
        .PCout      (PCout),
        .MARin      (MARin),
        .IncPC      (IncPC),
        .Zin        (Zin),
        .Zlowout    (Zlowout),
        .PCin       (PCin),
        .Read       (Read),
        .MDRin      (MDRin),
        .MDRout     (MDRout),
        .IRin       (IRin),
        .Gra        (Gra),
        .Rout       (Rout),
        .CONin      (CONin),
        .Yin        (Yin),
        .Cout       (Cout),
        .ADD        (ADD),
        .busy       (busy),
        .done       (done),
        .not_branch (not_branch),
        .mem_err    (mem_err)
`ifdef BRANCH_SEQ_STATS_EN
        ,
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Index i of exp_q is the state visible after the i-th edge following the start edge.
    task automatic run_seq(input string tag, input logic [4:0] op, input logic br,
                           input int ready_at, input int lat,
                           input logic exp_nb, input logic exp_err);
        int last;
        int done_idx;
        last      = exp_q.size() - 1;
        done_idx  = -1;
        ir_op     = op;
        branch    = br;
        mem_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= last; i++) begin
            if (i == ready_at) mem_ready = 1'b1;
            check($sformatf("%s_strb%0d", tag, i), 32'(strobes), 32'(exp_q[i]));
            check($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
            check($sformatf("%s_done%0d", tag, i), 32'(done), 32'(i == last));
            if (done) done_idx = i;
            if (i == 0) check($sformatf("%s_errclr", tag), 32'(mem_err), 32'd0);
            if (i == last) begin
                check($sformatf("%s_nb", tag), 32'(not_branch), 32'(exp_nb));
                check($sformatf("%s_err", tag), 32'(mem_err), 32'(exp_err));
            end else begin
                check($sformatf("%s_nb%0d", tag, i), 32'(not_branch), 32'd0);
            end
            // Flipping the flag inside T6 must not disturb the PC update decision.
            if (exp_q[i] == S_T6T || exp_q[i] == S_T6N) branch = ~br;
            tick();
        end
        check($sformatf("%s_lat", tag), 32'(done_idx), 32'(lat));
        check($sformatf("%s_idle_busy", tag), 32'(busy), 32'd0);
        check($sformatf("%s_idle_done", tag), 32'(done), 32'd0);
        check($sformatf("%s_sticky_err", tag), 32'(mem_err), 32'(exp_err));
        mem_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        ir_op     = '0;
        mem_ready = 1'b0;
        branch    = 1'b0;
        #1;
        check("rst_strobes", 32'(strobes), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Taken branch, no memory wait: PCin in T1 and T6, CONin only in T3.
        exp_q = '{S_T0, S_T1, S_T1W, S_T2, S_NONE, S_T3, S_T4, S_T5, S_T6T, S_NONE};
        run_seq("br_taken", 5'b10010, 1'b1, 1, 9, 1'b0, 1'b0);

        // Not-taken branch: T6 keeps Zlowout but drops PCin.
        exp_q = '{S_T0, S_T1, S_T1W, S_T2, S_NONE, S_T3, S_T4, S_T5, S_T6N, S_NONE};
        run_seq("br_nottaken", 5'b10010, 1'b0, 1, 9, 1'b0, 1'b0);

        // Two memory wait cycles stretch T1W.
        exp_q = '{S_T0, S_T1, S_T1W, S_T1W, S_T1W, S_T2, S_NONE, S_T3, S_T4, S_T5, S_T6T, S_NONE};
        run_seq("br_wait2", 5'b10010, 1'b1, 4, 11, 1'b0, 1'b0);

        // Non-branch opcode returns after CHK with not_branch.
        exp_q = '{S_T0, S_T1, S_T1W, S_T2, S_NONE, S_NONE};
        run_seq("nonbr_add", 5'b00011, 1'b1, 1, 5, 1'b1, 1'b0);

        // Memory never ready: eight T1W cycles then DONE with mem_err.
        exp_q = '{S_T0, S_T1, S_T1W, S_T1W, S_T1W, S_T1W, S_T1W, S_T1W, S_T1W, S_T1W, S_NONE};
        run_seq("timeout", 5'b10010, 1'b1, -1, 10, 1'b0, 1'b1);

        // A new start clears the sticky error.
        exp_q = '{S_T0, S_T1, S_T1W, S_T2, S_NONE, S_NONE};
        run_seq("errclear", 5'b00100, 1'b0, 2, 5, 1'b1, 1'b0);

        // Start while busy is ignored: a pulse in T1 must not restart at T0.
        ir_op = 5'b10010; branch = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_ignored", 32'(strobes), 32'(S_T1W));
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        mem_ready = 1'b0;
        check("busy_start_idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of T4.
        ir_op = 5'b10010; branch = 1'b1; mem_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("pre_rst_t4", 32'(strobes), 32'(S_T4));
        #2;
        reset = 1'b1;
        #1;
        check("midrst_strobes", 32'(strobes), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        tick();
        reset = 1'b0;
        mem_ready = 1'b0;
        begin
            int seen_done;
            seen_done = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (done || busy) seen_done++;
            end
            check("midrst_no_done", 32'(seen_done), 32'd0);
        end

`ifdef BRANCH_SEQ_STATS_EN
        check("stats_rst_taken", 32'(taken_cnt), 32'd0);
        check("stats_rst_nottaken", 32'(nottaken_cnt), 32'd0);
        for (int k = 0; k < 5; k++) begin
            if (k < 3) exp_q = '{S_T0, S_T1, S_T1W, S_T2, S_NONE, S_T3, S_T4, S_T5, S_T6T, S_NONE};
            else       exp_q = '{S_T0, S_T1, S_T1W, S_T2, S_NONE, S_T3, S_T4, S_T5, S_T6N, S_NONE};
            run_seq($sformatf("stats_br%0d", k), 5'b10010, (k < 3), 1, 9, 1'b0, 1'b0);
        end
        check("stats_taken3", 32'(taken_cnt), 32'd3);
        check("stats_nottaken2", 32'(nottaken_cnt), 32'd2);
        exp_q = '{S_T0, S_T1, S_T1W, S_T2, S_NONE, S_NONE};
        run_seq("stats_nonbr", 5'b00011, 1'b1, 1, 5, 1'b1, 1'b0);
        check("stats_nonbr_taken", 32'(taken_cnt), 32'd3);
        check("stats_nonbr_nottaken", 32'(nottaken_cnt), 32'd2);
        dut.u_stats.taken_q = 16'hFFFF;
        exp_q = '{S_T0, S_T1, S_T1W, S_T2, S_NONE, S_T3, S_T4, S_T5, S_T6T, S_NONE};
        run_seq("stats_wrap", 5'b10010, 1'b1, 1, 9, 1'b0, 1'b0);
        check("stats_wrap_taken", 32'(taken_cnt), 32'd0);
        check("stats_wrap_nottaken", 32'(nottaken_cnt), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
